contador_programa: RTL and testbench

//  - PC register and fetch sequencer for the RV32I core; consumes z_branch from the branch-condition stage.
//  - Holds the current PC and issues one instruction-memory request per instruction.
//  - Computes the next PC (pc+4, branch, JAL, JALR) when the core retires the current instruction.
//  - Flags a misaligned next-PC as a sticky fault and counts retired instructions.

---
 rtl/contador_programa_pkg.sv | 14 +
 rtl/contador_programa_calc_siguiente_pc.sv | 26 ++
 rtl/contador_programa.sv | 82 ++++++++
 tb/tb_contador_programa.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/contador_programa_pkg.sv
// Shared definitions for the RV32I PC/fetch sequencer: FSM states and datapath constants.
package contador_programa_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      ARRANQUE = 2'd0,
      PEDIR    = 2'd1,
      EJECUTAR = 2'd2,
      ERROR    = 2'd3
   } estado_t;

endpackage

// File: rtl/contador_programa_calc_siguiente_pc.sv
// Next-PC selection: JALR > JAL > taken branch > sequential; all adds wrap modulo 2^32.
module calc_siguiente_pc
   import contador_programa_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   input  logic            es_jal,
   input  logic            es_jalr,
   input  logic            es_branch,
   input  logic            z_branch,
   output logic [XLEN-1:0] sig_pc
);

   always_comb begin
      sig_pc = pc + PC_INC;
      if (es_jalr) begin
         sig_pc = (rs1 + imm) & ~32'h1;
      end else if (es_jal) begin
         sig_pc = pc + imm;
      end else if (es_branch && z_branch) begin
         sig_pc = pc + imm;
      end
   end

endmodule

// File: rtl/contador_programa.sv
// PC register and fetch sequencer: one fetch per instruction, next PC on retire,
// sticky misaligned-target fault and retired-instruction counter.
module contador_programa
   import contador_programa_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        avanzar,
   input  logic        es_branch,
   input  logic        es_jal,
   input  logic        es_jalr,
   input  logic        z_branch,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_mas_4,
   output logic        instr_valida,
   output logic        err_desalineado,
   output logic [31:0] n_retiradas
);

   estado_t     estado, estado_sig;
   logic [31:0] sig_pc;
   logic        desalineado;
   logic        retira;

   calc_siguiente_pc u_calc (
      .pc        (pc),
      .imm       (imm),
      .rs1       (rs1),
      .es_jal    (es_jal),
      .es_jalr   (es_jalr),
      .es_branch (es_branch),
      .z_branch  (z_branch),
      .sig_pc    (sig_pc)
   );

   assign desalineado = |sig_pc[1:0];
   assign retira      = (estado == EJECUTAR) && avanzar && !desalineado;
   assign pc_mas_4    = pc + PC_INC;
   assign imem_addr   = pc;

   always_comb begin
      estado_sig = estado;
      case (estado)
         ARRANQUE: estado_sig = PEDIR;
         PEDIR:    if (imem_ack) estado_sig = EJECUTAR;
         EJECUTAR: if (avanzar) estado_sig = desalineado ? ERROR : PEDIR;
         ERROR:    estado_sig = ERROR;
         default:  estado_sig = ARRANQUE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         estado          <= ARRANQUE;
         pc              <= RESET_VECTOR;
         imem_req        <= 1'b0;
         instr_valida    <= 1'b0;
         err_desalineado <= 1'b0;
         n_retiradas     <= '0;
      end else begin
         estado       <= estado_sig;
         imem_req     <= (estado_sig == PEDIR);
         instr_valida <= (estado_sig == EJECUTAR);
         if (estado_sig == ERROR) begin
            err_desalineado <= 1'b1;
         end
         if (retira) begin
            pc          <= sig_pc;
            n_retiradas <= n_retiradas + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_contador_programa.sv
// Directed self-checking bench for contador_programa.
module tb_contador_programa;

   logic        clk = 1'b0;
   logic        nreset;
   logic        avanzar;
   logic        es_branch;
   logic        es_jal;
   logic        es_jalr;
   logic        z_branch;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pc_mas_4;
   logic        instr_valida;
   logic        err_desalineado;
   logic [31:0] n_retiradas;

   int unsigned total = 0;
   int unsigned bad   = 0;

   contador_programa #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .avanzar         (avanzar),
      .es_branch       (es_branch),
      .es_jal          (es_jal),
      .es_jalr         (es_jalr),
      .z_branch        (z_branch),
      .imm             (imm),
      .rs1             (rs1),
      .imem_ack        (imem_ack),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .pc              (pc),
      .pc_mas_4        (pc_mas_4),
      .instr_valida    (instr_valida),
      .err_desalineado (err_desalineado),
      .n_retiradas     (n_retiradas)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      avanzar = 0; es_branch = 0; es_jal = 0; es_jalr = 0; z_branch = 0;
      imm = '0; rs1 = '0; imem_ack = 0;
   endtask

   // Reset then release; leaves the DUT in ARRANQUE just after the reset edge.
   task automatic do_reset();
      clear_inputs();
      nreset = 0;
      tick();
      nreset = 1;
   endtask

   // Acks the pending fetch; ok=1 once instr_valida is seen within the cycle budget.
   task automatic fetch(output logic ok);
      imem_ack = 1;
      tick();
      for (int i = 0; i < 20; i++) begin
         if (instr_valida) break;
         tick();
      end
      ok = instr_valida;
      imem_ack = 0;
   endtask

   task automatic retire(input logic b, input logic j, input logic jr, input logic z,
                         input logic [31:0] imm_v, input logic [31:0] rs1_v);
      avanzar = 1; es_branch = b; es_jal = j; es_jalr = jr; z_branch = z;
      imm = imm_v; rs1 = rs1_v;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      imem_ack = 1;
      nreset = 0;
      tick();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      total++; if (instr_valida !== 1'b0) begin bad++; $display("FAIL reset_valida got=%b exp=0", instr_valida); end
      total++; if (err_desalineado !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_desalineado); end
      total++; if (n_retiradas !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", n_retiradas); end
      nreset = 1;
      tick();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL arranque_req got=%b exp=1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL arranque_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
      tick();  // ack still held high from test_reset
      for (int i = 0; i < 3; i++) begin
         total++; if (instr_valida !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL seq_valida[%0d] got=%b/%b exp=1/0", i, instr_valida, imem_req);
         end
         avanzar = 1;
         tick();
         avanzar = 0;
         total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
         if (i < 2) tick();
      end
      imem_ack = 0;
      total++; if (n_retiradas !== 32'd3) begin bad++; $display("FAIL seq_cnt got=%0d exp=3", n_retiradas); end
      total++; if (pc_mas_4 !== 32'h10) begin bad++; $display("FAIL seq_pc4 got=%h exp=10", pc_mas_4); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_branch();
      logic ok;
      do_reset(); tick();
      fetch(ok); retire(0, 1, 0, 0, 32'h10, 0);
      total++; if (pc !== 32'h10) begin bad++; $display("FAIL br_setup got=%h exp=10", pc); end
      fetch(ok); retire(1, 0, 0, 1, 32'hFFFF_FFF8, 0);
      total++; if (pc !== 32'h08) begin bad++; $display("FAIL br_taken got=%h exp=08", pc); end
      fetch(ok); retire(0, 1, 0, 0, 32'h8, 0);
      fetch(ok); retire(1, 0, 0, 0, 32'hFFFF_FFF8, 0);
      total++; if (pc !== 32'h14) begin bad++; $display("FAIL br_not_taken got=%h exp=14", pc); end
      fetch(ok); retire(0, 0, 0, 1, 32'h100, 0);
      total++; if (pc !== 32'h18) begin bad++; $display("FAIL br_z_only got=%h exp=18", pc); end
      total++; if (n_retiradas !== 32'd5) begin bad++; $display("FAIL br_cnt got=%0d exp=5", n_retiradas); end
   endtask

   task automatic test_jalr_priority();
      logic ok;
      do_reset(); tick();
      fetch(ok); retire(0, 1, 0, 0, 32'h20, 0);
      fetch(ok); retire(1, 1, 1, 1, 32'h4, 32'h101);
      total++; if (pc !== 32'h104) begin bad++; $display("FAIL jalr_prio got=%h exp=104", pc); end
   endtask

   task automatic test_wrap();
      logic ok;
      do_reset(); tick();
      fetch(ok); retire(0, 1, 0, 0, 32'hFFFF_FFFC, 0);
      total++; if (pc_mas_4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", pc_mas_4); end
      fetch(ok); retire(0, 0, 0, 0, 0, 0);
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
   endtask

   task automatic test_misaligned();
      logic ok;
      do_reset(); tick();
      fetch(ok); retire(0, 1, 0, 0, 32'h20, 0);
      fetch(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL mis_fetch_timeout got=%b exp=1", ok); end
      retire(0, 1, 0, 0, 32'h2, 0);
      total++; if (err_desalineado !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", err_desalineado); end
      total++; if (pc !== 32'h20) begin bad++; $display("FAIL mis_pc got=%h exp=20", pc); end
      total++; if (n_retiradas !== 32'd1) begin bad++; $display("FAIL mis_cnt got=%0d exp=1", n_retiradas); end
      imem_ack = 1; avanzar = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (imem_req !== 1'b0 || instr_valida !== 1'b0 || err_desalineado !== 1'b1 || pc !== 32'h20) begin
            bad++; $display("FAIL mis_stuck[%0d] got=req%b val%b err%b pc%h exp=req0 val0 err1 pc00000020",
                            i, imem_req, instr_valida, err_desalineado, pc);
         end
      end
      clear_inputs();
      do_reset();
      total++; if (err_desalineado !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", err_desalineado); end
   endtask

   task automatic test_ack_delay();
      logic ok;
      do_reset(); tick();
      fetch(ok); retire(0, 1, 0, 0, 32'h40, 0);
      for (int i = 0; i < 5; i++) begin
         avanzar = (i % 2 == 0);
         tick();
         total++; if (imem_req !== 1'b1 || instr_valida !== 1'b0 || pc !== 32'h40 || n_retiradas !== 32'd1) begin
            bad++; $display("FAIL delay_wait[%0d] got=req%b val%b pc%h cnt%0d exp=req1 val0 pc00000040 cnt1",
                            i, imem_req, instr_valida, pc, n_retiradas);
         end
      end
      avanzar = 0;
      fetch(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL delay_fetch got=%b exp=1", ok); end
      retire(0, 0, 0, 0, 0, 0);
      total++; if (pc !== 32'h44) begin bad++; $display("FAIL delay_next got=%h exp=44", pc); end
   endtask

   task automatic test_reset_mid_fetch();
      logic ok;
      do_reset(); tick();
      fetch(ok); retire(0, 1, 0, 0, 32'h80, 0);
      imem_ack = 1; avanzar = 1; nreset = 0;
      tick();
      total++; if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valida !== 1'b0 || n_retiradas !== 32'h0 || err_desalineado !== 1'b0) begin
         bad++; $display("FAIL rst_mid got=pc%h req%b val%b cnt%0d err%b exp=pc00000000 req0 val0 cnt0 err0",
                         pc, imem_req, instr_valida, n_retiradas, err_desalineado);
      end
      nreset = 1;
      tick();
      total++; if (imem_req !== 1'b1 || instr_valida !== 1'b0) begin
         bad++; $display("FAIL rst_mid_arranque got=req%b val%b exp=req1 val0", imem_req, instr_valida);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      nreset = 0;
      test_reset();
      test_sequential();
      test_branch();
      test_jalr_priority();
      test_wrap();
      test_misaligned();
      test_ack_delay();
      test_reset_mid_fetch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
